// File: rtl/flash_seq_pkg.sv
// Shared encodings, JEDEC command constants and the unlock/command sequence table
// for the parallel-flash command sequencer.
package flash_seq_pkg;

  typedef enum logic [1:0] {
    OP_READ         = 2'd0,
    OP_PROGRAM      = 2'd1,
    OP_SECTOR_ERASE = 2'd2,
    OP_CHIP_ERASE   = 2'd3
  } op_t;

  localparam logic [15:0] UNLOCK_A1 = 16'h5555;
  localparam logic [15:0] UNLOCK_A2 = 16'h2AAA;

  localparam logic [7:0] CMD_AA     = 8'hAA;
  localparam logic [7:0] CMD_55     = 8'h55;
  localparam logic [7:0] CMD_PROG   = 8'hA0;
  localparam logic [7:0] CMD_ERASE  = 8'h80;
  localparam logic [7:0] CMD_SECTOR = 8'h30;
  localparam logic [7:0] CMD_CHIP   = 8'h10;

  localparam int unsigned STEP_W = 3;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RD_CYC   = 3'd1,
    S_WR_CYC   = 3'd2,
    S_POLL_RD  = 3'd3,
    S_POLL_CMP = 3'd4,
    S_DONE     = 3'd5,
    S_ERR      = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    B_IDLE     = 3'd0,
    B_SETUP    = 3'd1,
    B_WE_LOW   = 3'd2,
    B_RECOV    = 3'd3,
    B_RD       = 3'd4,
    B_RD_RECOV = 3'd5
  } bus_phase_t;

  // One write step: fixed addr/data, or substitute the latched target addr / program data.
  typedef struct packed {
    logic        use_tgt_addr;
    logic        use_wdata;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_step_t;

  // Index of the final write step for a write-type op.
  function automatic logic [STEP_W-1:0] seq_last(input op_t op);
    return (op == OP_PROGRAM) ? STEP_W'(3) : STEP_W'(5);
  endfunction

  // Command table lookup for write-type ops.
  function automatic cmd_step_t cmd_step(input op_t op, input logic [STEP_W-1:0] step);
    cmd_step_t s;
    s.use_tgt_addr = 1'b0;
    s.use_wdata    = 1'b0;
    s.addr         = UNLOCK_A1;
    s.data         = CMD_AA;
    case (step)
      3'd1: begin
        s.addr = UNLOCK_A2;
        s.data = CMD_55;
      end
      3'd2: s.data = (op == OP_PROGRAM) ? CMD_PROG : CMD_ERASE;
      3'd3: begin
        if (op == OP_PROGRAM) begin
          s.use_tgt_addr = 1'b1;
          s.use_wdata    = 1'b1;
        end
      end
      3'd4: begin
        s.addr = UNLOCK_A2;
        s.data = CMD_55;
      end
      3'd5: begin
        if (op == OP_CHIP_ERASE) begin
          s.data = CMD_CHIP;
        end else begin
          s.use_tgt_addr = 1'b1;
          s.data         = CMD_SECTOR;
        end
      end
      default: ;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Single flash bus-cycle timing engine: one write (setup / WE pulse / recovery)
// or one read (OE access / recovery) per start. Strobes are registered.
module flash_bus_cycle
  import flash_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned WE_PULSE_CYC = 4,
  parameter int unsigned WE_HIGH_CYC  = 2,
  parameter int unsigned OE_ACC_CYC   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        data,
  input  logic [7:0]        dq_in,
  output logic              cyc_done_c,
  output logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [7:0]        dq_out,
  output logic              dq_oe,
  output logic              ce_n,
  output logic              we_n,
  output logic              oe_n
);

  localparam int unsigned MAX_A   = (WE_PULSE_CYC > WE_HIGH_CYC) ? WE_PULSE_CYC : WE_HIGH_CYC;
  localparam int unsigned MAX_CYC = (MAX_A > OE_ACC_CYC) ? MAX_A : OE_ACC_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] WE_LAST = CNT_W'(WE_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LAST = CNT_W'(WE_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] OE_LAST = CNT_W'(OE_ACC_CYC - 1);

  bus_phase_t       ph, ph_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             ce_n_nxt, we_n_nxt, oe_n_nxt, dq_oe_nxt;

  // Phase register, registered strobes, address/data launch and read capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph       <= B_IDLE;
      cnt      <= '0;
      ce_n     <= 1'b1;
      we_n     <= 1'b1;
      oe_n     <= 1'b1;
      dq_oe    <= 1'b0;
      bus_addr <= '0;
      dq_out   <= '0;
      rd_data  <= '0;
    end else begin
      ph    <= ph_nxt;
      cnt   <= cnt_nxt;
      ce_n  <= ce_n_nxt;
      we_n  <= we_n_nxt;
      oe_n  <= oe_n_nxt;
      dq_oe <= dq_oe_nxt;
      if (start) begin
        bus_addr <= addr;
        if (is_write) dq_out <= data;
      end
      if (ph == B_RD && cnt == OE_LAST) rd_data <= dq_in;
    end
  end

  // Phase sequencing; a new start may overlap the final cycle of the previous bus cycle.
  always_comb begin
    ph_nxt     = ph;
    cnt_nxt    = cnt;
    cyc_done_c = 1'b0;
    case (ph)
      B_SETUP: begin
        ph_nxt  = B_WE_LOW;
        cnt_nxt = '0;
      end
      B_WE_LOW: begin
        if (cnt == WE_LAST) begin
          ph_nxt  = B_RECOV;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      B_RECOV: begin
        if (cnt == HI_LAST) begin
          cyc_done_c = 1'b1;
          ph_nxt     = B_IDLE;
          cnt_nxt    = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      B_RD: begin
        if (cnt == OE_LAST) begin
          ph_nxt  = B_RD_RECOV;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      B_RD_RECOV: begin
        cyc_done_c = 1'b1;
        ph_nxt     = B_IDLE;
      end
      default: ;
    endcase
    if (start) begin
      ph_nxt  = is_write ? B_SETUP : B_RD;
      cnt_nxt = '0;
    end
    ce_n_nxt  = !(ph_nxt == B_SETUP || ph_nxt == B_WE_LOW || ph_nxt == B_RD);
    we_n_nxt  = (ph_nxt != B_WE_LOW);
    oe_n_nxt  = (ph_nxt != B_RD);
    dq_oe_nxt = (ph_nxt == B_SETUP || ph_nxt == B_WE_LOW);
  end

endmodule

// File: rtl/flash_cmd_sequencer.sv
// Flash command sequencer: accepts one high-level op, walks the JEDEC unlock table
// through the bus-cycle engine, then polls DQ6 toggle until stable or timeout.
module flash_cmd_sequencer
  import flash_seq_pkg::*;
#(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned WE_PULSE_CYC = 4,
  parameter int unsigned WE_HIGH_CYC  = 2,
  parameter int unsigned OE_ACC_CYC   = 3,
  parameter int unsigned POLL_MAX     = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        rdata,
  output logic [ADDR_W-1:0] f_addr,
  output logic [7:0]        f_dq_out,
  output logic              f_dq_oe,
  input  logic [7:0]        f_dq_in,
  output logic              CE_N,
  output logic              WE_N,
  output logic              OE_N
);

  localparam int unsigned PCNT_W = $clog2(POLL_MAX + 1);

  seq_state_t        state, state_nxt;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        wdata_q;
  logic [STEP_W-1:0] step_q, step_nxt;
  logic [PCNT_W-1:0] poll_cnt;
  logic              prev_dq6, have_prev;

  logic              start_c, st_write_c;
  logic [ADDR_W-1:0] st_addr_c;
  logic [7:0]        st_data_c;
  logic              cyc_done_c;
  logic [7:0]        cap_data;
  cmd_step_t         nxt_cmd_c;
  logic [ADDR_W-1:0] poll_addr_c;
  logic              poll_ok_c;

  // Bus-cycle engine: the only driver of the flash pins.
  flash_bus_cycle #(
    .ADDR_W      (ADDR_W),
    .WE_PULSE_CYC(WE_PULSE_CYC),
    .WE_HIGH_CYC (WE_HIGH_CYC),
    .OE_ACC_CYC  (OE_ACC_CYC)
  ) u_bus (
    .clk       (clk),
    .reset     (reset),
    .start     (start_c),
    .is_write  (st_write_c),
    .addr      (st_addr_c),
    .data      (st_data_c),
    .dq_in     (f_dq_in),
    .cyc_done_c(cyc_done_c),
    .rd_data   (cap_data),
    .bus_addr  (f_addr),
    .dq_out    (f_dq_out),
    .dq_oe     (f_dq_oe),
    .ce_n      (CE_N),
    .we_n      (WE_N),
    .oe_n      (OE_N)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Op latch, step index, poll counter and previous-DQ6 tracking.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q      <= OP_READ;
      addr_q    <= '0;
      wdata_q   <= '0;
      step_q    <= '0;
      poll_cnt  <= '0;
      prev_dq6  <= 1'b0;
      have_prev <= 1'b0;
    end else begin
      step_q <= step_nxt;
      if (state == S_IDLE && req) begin
        op_q      <= op_t'(op);
        addr_q    <= addr;
        wdata_q   <= wdata;
        poll_cnt  <= '0;
        have_prev <= 1'b0;
      end
      if (state == S_POLL_RD && cyc_done_c) poll_cnt <= poll_cnt + PCNT_W'(1);
      if (state == S_POLL_CMP) begin
        prev_dq6  <= cap_data[6];
        have_prev <= 1'b1;
      end
    end
  end

  // Registered handshake outputs, derived from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      busy <= (state_nxt inside {S_RD_CYC, S_WR_CYC, S_POLL_RD, S_POLL_CMP});
      done <= (state_nxt == S_DONE) || (state_nxt == S_ERR);
      err  <= (state_nxt == S_ERR);
      if (state == S_RD_CYC && cyc_done_c) rdata <= cap_data;
    end
  end

  // Table lookups and poll decision helpers.
  always_comb begin
    nxt_cmd_c   = cmd_step(op_q, step_q + STEP_W'(1));
    poll_addr_c = (op_q == OP_CHIP_ERASE) ? '0 : addr_q;
    poll_ok_c   = have_prev && (cap_data[6] == prev_dq6);
  end

  // Next-state logic and bus-cycle issue.
  always_comb begin
    state_nxt  = state;
    step_nxt   = step_q;
    start_c    = 1'b0;
    st_write_c = 1'b0;
    st_addr_c  = addr_q;
    st_data_c  = wdata_q;
    case (state)
      S_IDLE: begin
        if (req) begin
          start_c   = 1'b1;
          step_nxt  = '0;
          st_addr_c = addr;
          if (op_t'(op) == OP_READ) begin
            state_nxt = S_RD_CYC;
          end else begin
            state_nxt  = S_WR_CYC;
            st_write_c = 1'b1;
            st_addr_c  = ADDR_W'(UNLOCK_A1);
            st_data_c  = CMD_AA;
          end
        end
      end
      S_RD_CYC: begin
        if (cyc_done_c) state_nxt = S_DONE;
      end
      S_WR_CYC: begin
        if (cyc_done_c) begin
          start_c = 1'b1;
          if (step_q == seq_last(op_q)) begin
            state_nxt = S_POLL_RD;
            step_nxt  = '0;
            st_addr_c = poll_addr_c;
          end else begin
            step_nxt   = step_q + STEP_W'(1);
            st_write_c = 1'b1;
            st_addr_c  = nxt_cmd_c.use_tgt_addr ? addr_q : ADDR_W'(nxt_cmd_c.addr);
            st_data_c  = nxt_cmd_c.use_wdata ? wdata_q : nxt_cmd_c.data;
          end
        end
      end
      S_POLL_RD: begin
        if (cyc_done_c) state_nxt = S_POLL_CMP;
      end
      S_POLL_CMP: begin
        if (poll_ok_c) begin
          state_nxt = S_DONE;
        end else if (poll_cnt == PCNT_W'(POLL_MAX)) begin
          state_nxt = S_ERR;
        end else begin
          state_nxt = S_POLL_RD;
          start_c   = 1'b1;
          st_addr_c = poll_addr_c;
        end
      end
      S_DONE, S_ERR: begin
        state_nxt = S_IDLE;
        step_nxt  = '0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_flash_cmd_sequencer.sv
// Bench for flash_cmd_sequencer: flash model with DQ6 toggle modes, bus monitor
// scoreboarding write cycles, read cycles and done results against expectations.
module tb_flash_cmd_sequencer;
  import flash_seq_pkg::*;

  localparam int unsigned TB_POLL_MAX = 8;

  logic        clk, reset, req;
  logic [1:0]  op;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        busy, done, err;
  logic [7:0]  rdata;
  logic [15:0] f_addr;
  logic [7:0]  f_dq_out, f_dq_in;
  logic        f_dq_oe, CE_N, WE_N, OE_N;

  flash_cmd_sequencer #(
    .ADDR_W(16), .WE_PULSE_CYC(4), .WE_HIGH_CYC(2), .OE_ACC_CYC(3), .POLL_MAX(TB_POLL_MAX)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .op(op), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .f_addr(f_addr), .f_dq_out(f_dq_out), .f_dq_oe(f_dq_oe), .f_dq_in(f_dq_in),
    .CE_N(CE_N), .WE_N(WE_N), .OE_N(OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    op_t         op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  mem;
    int          mode;   // 0: plain data, 1: DQ6 toggles 5 times then holds, 2: toggles forever
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  typedef struct {
    logic       err;
    logic       chk_rd;
    logic [7:0] rdata;
  } done_t;

  wr_t         exp_wr[$];
  logic [15:0] exp_rd[$];
  done_t       exp_done[$];

  int   total = 0;
  int   bad = 0;
  int   rc = 0;
  int   rc_base = 0;
  int   rd_n;
  int   mode = 0;
  logic [7:0] mem = 8'h00;
  logic mon_en = 1'b1;
  logic oe_conflict = 1'b0;
  logic oe_missing = 1'b0;
  logic dq6_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Flash read model.
  always_comb begin
    rd_n = rc - rc_base;
    case (mode)
      1:       dq6_m = (rd_n < 5) ? rd_n[0] : 1'b0;
      2:       dq6_m = rd_n[0];
      default: dq6_m = 1'b0;
    endcase
    f_dq_in = (mode == 0) ? mem : {1'b0, dq6_m, 6'b010101};
  end

  // Bus monitor and result scoreboard, sampled on the falling edge.
  int          we_len = 0, oe_len = 0;
  logic [15:0] w_addr, r_addr;
  logic [7:0]  w_data;
  always @(negedge clk) begin
    if (!OE_N && f_dq_oe) oe_conflict = 1'b1;
    if (!WE_N) begin
      we_len++;
      w_addr = f_addr;
      w_data = f_dq_out;
      if (!f_dq_oe) oe_missing = 1'b1;
    end else if (we_len != 0) begin
      if (mon_en) begin
        if (exp_wr.size() == 0) chk("extra_write", 1, 0);
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          chk("wr_addr", w_addr, e.a);
          chk("wr_data", w_data, e.d);
          chk("we_low_len", we_len, 4);
        end
      end
      we_len = 0;
    end
    if (!OE_N) begin
      oe_len++;
      r_addr = f_addr;
    end else if (oe_len != 0) begin
      rc++;
      if (mon_en) begin
        if (exp_rd.size() == 0) chk("extra_read", 1, 0);
        else begin
          logic [15:0] ea;
          ea = exp_rd.pop_front();
          chk("rd_addr", r_addr, ea);
          chk("oe_low_len", oe_len, 3);
        end
      end
      oe_len = 0;
    end
    if (done) begin
      if (exp_done.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        done_t d;
        d = exp_done.pop_front();
        chk("done_err", err, d.err);
        if (d.chk_rd) chk("rdata", rdata, d.rdata);
      end
    end
  end

  task automatic push_wr(input logic [15:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_exp(input vec_t v);
    done_t d;
    int n;
    logic [15:0] pa;
    if (v.op == OP_READ) begin
      exp_rd.push_back(v.addr);
    end else begin
      push_wr(16'h5555, 8'hAA);
      push_wr(16'h2AAA, 8'h55);
      if (v.op == OP_PROGRAM) begin
        push_wr(16'h5555, 8'hA0);
        push_wr(v.addr, v.wdata);
      end else begin
        push_wr(16'h5555, 8'h80);
        push_wr(16'h5555, 8'hAA);
        push_wr(16'h2AAA, 8'h55);
        if (v.op == OP_SECTOR_ERASE) push_wr(v.addr, 8'h30);
        else                         push_wr(16'h5555, 8'h10);
      end
      n  = (v.mode == 2) ? int'(TB_POLL_MAX) : 6;
      pa = (v.op == OP_CHIP_ERASE) ? 16'h0000 : v.addr;
      for (int i = 0; i < n; i++) exp_rd.push_back(pa);
    end
    d.err    = (v.mode == 2);
    d.chk_rd = (v.op == OP_READ);
    d.rdata  = v.mem;
    exp_done.push_back(d);
  endtask

  task automatic wait_done(output int k, output bit seen);
    k = 0;
    seen = 0;
    while (!seen && k < 3000) begin
      @(negedge clk);
      k++;
      seen = done;
    end
    chk("done_seen", 32'(seen), 1);
  endtask

  task automatic run_op(input vec_t v);
    int k;
    bit seen;
    @(negedge clk);
    mode = v.mode;
    mem = v.mem;
    rc_base = rc;
    push_exp(v);
    req = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata;
    @(posedge clk);
    #1 req = 1'b0;
    chk("busy_after_accept", busy, 1);
    wait_done(k, seen);
    if (seen && v.op == OP_READ) chk("read_latency", k, 5);
    chk("busy_low_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("strobes_idle", {CE_N, WE_N, OE_N, f_dq_oe}, 4'b1110);
    chk("writes_left", exp_wr.size(), 0);
    chk("reads_left", exp_rd.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  vec_t vt[7];
  vec_t v5;

  initial begin
    int k, lows;
    bit seen;

    vt[0] = '{op: OP_READ,         addr: 16'h1234, wdata: 8'h00, mem: 8'h5A, mode: 0};
    vt[1] = '{op: OP_PROGRAM,      addr: 16'h0100, wdata: 8'hC3, mem: 8'h00, mode: 1};
    vt[2] = '{op: OP_SECTOR_ERASE, addr: 16'h3000, wdata: 8'h00, mem: 8'h00, mode: 1};
    vt[3] = '{op: OP_CHIP_ERASE,   addr: 16'hBEEF, wdata: 8'h00, mem: 8'h00, mode: 1};
    vt[4] = '{op: OP_PROGRAM,      addr: 16'h7FFF, wdata: 8'hA5, mem: 8'h00, mode: 2};
    vt[5] = '{op: OP_READ,         addr: 16'hFFFF, wdata: 8'h00, mem: 8'hA5, mode: 0};
    vt[6] = '{op: OP_READ,         addr: 16'h0000, wdata: 8'h00, mem: 8'h00, mode: 0};

    reset = 1'b1; req = 1'b0; op = 2'd0; addr = '0; wdata = '0;
    #1;
    chk("rst_strobes", {CE_N, WE_N, OE_N, f_dq_oe}, 4'b1110);
    chk("rst_flags", {busy, done, err}, 3'b000);
    chk("rst_rdata", rdata, 0);
    chk("rst_faddr", f_addr, 0);
    chk("rst_fdq_out", f_dq_out, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) run_op(vt[i]);

    // Reset during the WE_N pulse of the second write cycle.
    @(negedge clk);
    mon_en = 1'b0;
    mode = 1;
    rc_base = rc;
    req = 1'b1; op = OP_PROGRAM; addr = 16'h0200; wdata = 8'h11;
    @(posedge clk);
    #1 req = 1'b0;
    lows = 0;
    k = 0;
    while (lows < 6 && k < 200) begin
      @(negedge clk);
      k++;
      if (!WE_N) lows++;
    end
    chk("t5_reach_we2", lows, 6);
    reset = 1'b1;
    #1;
    chk("t5_strobes", {CE_N, WE_N, OE_N, f_dq_oe}, 4'b1110);
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_idle_after", {busy, CE_N}, 2'b01);
    mon_en = 1'b1;
    v5 = '{op: OP_READ, addr: 16'h0042, wdata: 8'h00, mem: 8'hC9, mode: 0};
    run_op(v5);

    // req held high through a PROGRAM and its done cycle.
    @(negedge clk);
    v5 = '{op: OP_PROGRAM, addr: 16'h0400, wdata: 8'h3C, mem: 8'h00, mode: 1};
    mode = 1;
    rc_base = rc;
    push_exp(v5);
    req = 1'b1; op = OP_PROGRAM; addr = 16'h0400; wdata = 8'h3C;
    @(posedge clk);
    wait_done(k, seen);
    chk("t6_busy_at_done", busy, 0);
    v5 = '{op: OP_READ, addr: 16'h0ABC, wdata: 8'h00, mem: 8'h77, mode: 0};
    mode = 0;
    mem = 8'h77;
    rc_base = rc;
    push_exp(v5);
    op = OP_READ; addr = 16'h0ABC;
    @(negedge clk);
    chk("t6_no_accept_in_done", {busy, CE_N}, 2'b01);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    chk("t6_accept_in_idle", {busy, OE_N}, 2'b10);
    wait_done(k, seen);
    @(negedge clk);
    chk("t6_writes_left", exp_wr.size(), 0);
    chk("t6_reads_left", exp_rd.size(), 0);
    chk("t6_done_left", exp_done.size(), 0);

    chk("dq_oe_during_oe", 32'(oe_conflict), 0);
    chk("dq_oe_missing_we", 32'(oe_missing), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
